// File: rtl/mux_pkg.sv
// rtl/mux_pkg.sv - shared constants, state type and helpers for the 8:1 mux scan sequencer
package mux_pkg;

  localparam int NCH   = 8;
  localparam int SEL_W = 3;

  // Prefixed so the enum never collides with the SETTLE timing parameter.
  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SETTLE = 2'd1,
    S_OUTPUT = 2'd2
  } state_t;

  function automatic logic [SEL_W-1:0] lowest_set(input logic [NCH-1:0] mask);
    logic [SEL_W-1:0] idx;
    idx = '0;
    for (int i = NCH - 1; i >= 0; i--) begin
      if (mask[i]) idx = SEL_W'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/mux_next_ch.sv
// rtl/mux_next_ch.sv - finds the next enabled channel above the current one
module mux_next_ch
  import mux_pkg::*;
(
  input  logic [NCH-1:0]   en_q,
  input  logic [SEL_W-1:0] cur_ch,
  output logic [SEL_W-1:0] nxt_ch,
  output logic             nxt_vld
);

  // Descending walk so the lowest qualifying index is the one left standing.
  always_comb begin
    nxt_ch  = '0;
    nxt_vld = 1'b0;
    for (int i = NCH - 1; i >= 0; i--) begin
      if (en_q[i] && (i > int'(cur_ch))) begin
        nxt_ch  = SEL_W'(i);
        nxt_vld = 1'b1;
      end
    end
  end

endmodule

// File: rtl/mux_scan_seq.sv
// rtl/mux_scan_seq.sv - walks enabled mux channels, samples y after a settle window, emits 8-bit frames
module mux_scan_seq
  import mux_pkg::*;
#(
  parameter int SETTLE = 2,
  parameter int CNT_W  = 4
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           start,
  input  logic           continuous,
  input  logic [NCH-1:0] ch_en,
  input  logic           y,
  output logic           s2,
  output logic           s1,
  output logic           s0,
  output logic           busy,
  output logic [NCH-1:0] frame,
  output logic           frame_valid,
  input  logic           frame_ready
);

  state_t           state;
  state_t           state_d;
  logic [NCH-1:0]   en_q;
  logic [NCH-1:0]   acc;
  logic [NCH-1:0]   acc_merged;
  logic [SEL_W-1:0] cur_ch;
  logic [CNT_W-1:0] cnt;
  logic [SEL_W-1:0] nxt_ch;
  logic             nxt_vld;
  logic             settle_done;
  logic             handshake;
  logic             load;

  mux_next_ch u_next_ch (
    .en_q    (en_q),
    .cur_ch  (cur_ch),
    .nxt_ch  (nxt_ch),
    .nxt_vld (nxt_vld)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_d;
  end

  // A scan load happens either from IDLE or back-to-back on a continuous handshake.
  always_comb begin
    settle_done = (state == S_SETTLE) && (cnt == CNT_W'(SETTLE - 1));
    handshake   = (state == S_OUTPUT) && frame_valid && frame_ready;
    load        = (|ch_en) && (((state == S_IDLE) && start) || (handshake && continuous));
    acc_merged         = acc;
    acc_merged[cur_ch] = y;
    state_d = state;
    case (state)
      S_IDLE:   if (load) state_d = S_SETTLE;
      S_SETTLE: if (settle_done && !nxt_vld) state_d = S_OUTPUT;
      S_OUTPUT: if (handshake) state_d = load ? S_SETTLE : S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      en_q        <= '0;
      acc         <= '0;
      cur_ch      <= '0;
      cnt         <= '0;
      busy        <= 1'b0;
      frame       <= '0;
      frame_valid <= 1'b0;
    end else begin
      busy <= (state_d != S_IDLE);
      if (handshake) frame_valid <= 1'b0;
      if (load) begin
        en_q   <= ch_en;
        acc    <= '0;
        cur_ch <= lowest_set(ch_en);
        cnt    <= '0;
      end else if (state == S_SETTLE) begin
        if (settle_done) begin
          acc <= acc_merged;
          cnt <= '0;
          if (nxt_vld) begin
            cur_ch <= nxt_ch;
          end else begin
            frame       <= acc_merged;
            frame_valid <= 1'b1;
          end
        end else begin
          cnt <= cnt + 1'b1;
        end
      end
    end
  end

  assign s2 = cur_ch[2];
  assign s1 = cur_ch[1];
  assign s0 = cur_ch[0];

endmodule

// File: tb/tb_mux_scan_seq.sv
// tb/tb_mux_scan_seq.sv - randomized self-checking bench for mux_scan_seq
module tb_mux_scan_seq;

  localparam int S = 2;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start;
  logic       continuous;
  logic [7:0] ch_en;
  logic       y;
  logic       s2, s1, s0;
  logic       busy;
  logic [7:0] frame;
  logic       frame_valid;
  logic       frame_ready;
  logic [7:0] mux_in;

  int total = 0;
  int bad   = 0;

  mux_scan_seq #(.SETTLE(S), .CNT_W(4)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .continuous  (continuous),
    .ch_en       (ch_en),
    .y           (y),
    .s2          (s2),
    .s1          (s1),
    .s0          (s0),
    .busy        (busy),
    .frame       (frame),
    .frame_valid (frame_valid),
    .frame_ready (frame_ready)
  );

  always #5 clk = ~clk;

  assign y = mux_in[{s2, s1, s0}];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  task automatic start_scan(input logic [7:0] en, input logic [7:0] m);
    @(negedge clk);
    mux_in = m;
    ch_en  = en;
    start  = 1'b1;
    @(negedge clk);
    start  = 1'b0;
  endtask

  // Entered at the negedge just after the edge that launched the scan.
  task automatic follow_scan(input logic [7:0] en, input logic [7:0] m, input string tag);
    int ch[$];
    for (int i = 0; i < 8; i++) if (en[i]) ch.push_back(i);
    for (int j = 0; j < ch.size() * S; j++) begin
      if (j > 0) @(negedge clk);
      chk({tag, "_sel"}, 32'({s2, s1, s0}), 32'(ch[j / S]));
      chk({tag, "_busy"}, 32'(busy), 32'd1);
      chk({tag, "_fv_lo"}, 32'(frame_valid), 32'd0);
    end
    @(negedge clk);
    chk({tag, "_fv_hi"}, 32'(frame_valid), 32'd1);
    chk({tag, "_frame"}, 32'(frame), 32'(m & en));
    chk({tag, "_sel_hold"}, 32'({s2, s1, s0}), 32'(ch[ch.size() - 1]));
  endtask

  task automatic accept(input string tag);
    frame_ready = 1'b1;
    @(negedge clk);
    frame_ready = 1'b0;
    chk({tag, "_fv_drop"}, 32'(frame_valid), 32'd0);
    chk({tag, "_idle"}, 32'(busy), 32'd0);
  endtask

  initial begin
    logic [7:0] en, m, fr;
    rst_n = 1'b1; start = 1'b0; continuous = 1'b0; ch_en = '0;
    frame_ready = 1'b0; mux_in = '0;

    #12 rst_n = 1'b0;
    #1;
    chk("rst_sel", 32'({s2, s1, s0}), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_fv", 32'(frame_valid), 32'd0);
    chk("rst_frame", 32'(frame), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_busy", 32'(busy), 32'd0);

    start_scan(8'hFF, 8'hA5);
    follow_scan(8'hFF, 8'hA5, "all");
    accept("all");

    start_scan(8'h81, 8'hFF);
    follow_scan(8'h81, 8'hFF, "edge");
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      start = ~start;
      ch_en = 8'($urandom);
      chk("bp_fv", 32'(frame_valid), 32'd1);
      chk("bp_frame", 32'(frame), 32'h81);
      chk("bp_busy", 32'(busy), 32'd1);
      chk("bp_sel", 32'({s2, s1, s0}), 32'd7);
    end
    start = 1'b0;
    accept("bp");
    @(negedge clk);
    chk("bp_frame_kept", 32'(frame), 32'h81);

    continuous = 1'b1;
    start_scan(8'h0F, 8'h3C);
    follow_scan(8'h0F, 8'h3C, "cont1");
    ch_en       = 8'hF0;
    frame_ready = 1'b1;
    @(negedge clk);
    frame_ready = 1'b0;
    continuous  = 1'b0;
    follow_scan(8'hF0, 8'h3C, "cont2");
    accept("cont2");

    for (int r = 0; r < 20; r++) begin
      en = 8'($urandom_range(1, 255));
      m  = 8'($urandom);
      start_scan(en, m);
      follow_scan(en, m, "rnd");
      for (int d = int'($urandom_range(0, 3)); d > 0; d--) begin
        @(negedge clk);
        chk("rnd_hold", 32'(frame_valid), 32'd1);
      end
      accept("rnd");
    end

    fr = frame;
    @(negedge clk);
    ch_en = 8'h00;
    start = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("zero_en_busy", 32'(busy), 32'd0);
      chk("zero_en_fv", 32'(frame_valid), 32'd0);
    end
    start = 1'b0;
    chk("zero_en_frame", 32'(frame), 32'(fr));

    start_scan(8'hFF, 8'($urandom));
    repeat (6) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_sel", 32'({s2, s1, s0}), 32'd0);
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_frame", 32'(frame), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      chk("post_rst_fv", 32'(frame_valid), 32'd0);
      chk("post_rst_idle", 32'(busy), 32'd0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1);
  end

endmodule
